// File: rtl/divisor_pkg.sv
// Shared types and defaults for the control_divisor clock divider.
package divisor_pkg;

    localparam int unsigned NDefault    = 32;
    localparam int unsigned HalfDefault = 750000;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPend
    } state_e;

endpackage

// File: rtl/control_divisor_if.sv
// Run/config handshake and divided-clock outputs of control_divisor.
// CONTROL_DIVISOR_STATUS_EN adds the periodos completed-period count.
interface control_divisor_if
    import divisor_pkg::*;
#(
    parameter int unsigned N = NDefault
) ();

    logic         en;
    logic         cfg_valid;
    logic [N-1:0] cfg_half;
    logic         cfg_ready;
    logic         clock_out;
    logic         tick;
    logic         busy;
`ifdef CONTROL_DIVISOR_STATUS_EN
    logic [15:0]  periodos;
`endif

    modport master (
        output en, cfg_valid, cfg_half,
`ifdef CONTROL_DIVISOR_STATUS_EN
        input  periodos,
`endif
        input  cfg_ready, clock_out, tick, busy
    );

    modport slave (
        input  en, cfg_valid, cfg_half,
`ifdef CONTROL_DIVISOR_STATUS_EN
        output periodos,
`endif
        output cfg_ready, clock_out, tick, busy
    );

endinterface

// File: rtl/contador_fase.sv
// Phase counter for one divided-clock period (0..2H-1) with terminal-count flags.
module contador_fase
    import divisor_pkg::*;
#(
    parameter int unsigned N = NDefault
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic [N-1:0] half,
    output logic         at_half,
    output logic         at_wrap
);

    // One extra bit so 2H never overflows.
    logic [N:0] cnt_q, cnt_d;
    logic [N:0] half_m1;
    logic [N:0] period_m1;

    assign half_m1   = {1'b0, half} - (N+1)'(1);
    assign period_m1 = {half, 1'b0} - (N+1)'(1);

    assign at_half = (cnt_q == half_m1);
    // >= keeps the count bounded even if H shrank while the count was high.
    assign at_wrap = (cnt_q >= period_m1);

    always_comb begin
        cnt_d = cnt_q + (N+1)'(1);
        if (!run || at_wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/control_divisor.sv
// Programmable square-wave divider: low for H clk cycles, high for H, reconfigured only at wrap.
// CONTROL_DIVISOR_STATUS_EN adds the periodos completed-period counter.
module control_divisor
    import divisor_pkg::*;
#(
    parameter int unsigned N            = NDefault,
    parameter int unsigned HALF_DEFAULT = HalfDefault
) (
    input  logic               clk,
    input  logic               rst_n,
    control_divisor_if.slave   bus
);

    localparam logic [N-1:0] HalfRst = (HALF_DEFAULT == 0) ? N'(1) : N'(HALF_DEFAULT);

    state_e       state_q, state_d;
    logic [N-1:0] half_q, half_d;
    logic [N-1:0] shadow_q, shadow_d;
    logic         busy_q, busy_d;
    logic         clock_out_q, clock_out_d;
    logic         tick_q, tick_d;
    logic [N-1:0] cfg_val;
    logic         xfer;
    logic         run;
    logic         at_half;
    logic         at_wrap;

    assign bus.cfg_ready = (state_q != StPend);
    assign xfer          = bus.cfg_valid && bus.cfg_ready;
    assign cfg_val       = (bus.cfg_half == '0) ? N'(1) : bus.cfg_half;
    assign run           = (state_q != StIdle);

    contador_fase #(
        .N(N)
    ) u_fase (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .half   (half_q),
        .at_half(at_half),
        .at_wrap(at_wrap)
    );

    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        shadow_d    = shadow_q;
        busy_d      = busy_q;
        clock_out_d = clock_out_q;
        tick_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    half_d = cfg_val;
                end
                if (bus.en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Stopping at wrap: a config offered on that same cycle can land in H directly.
                if (at_wrap && !bus.en) begin
                    state_d = StIdle;
                    if (xfer) begin
                        half_d = cfg_val;
                    end
                end else if (xfer) begin
                    shadow_d = cfg_val;
                    busy_d   = 1'b1;
                    state_d  = StPend;
                end
            end
            StPend: begin
                if (at_wrap) begin
                    half_d  = shadow_q;
                    busy_d  = 1'b0;
                    state_d = bus.en ? StRun : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q == StIdle) begin
            clock_out_d = 1'b0;
        end else if (at_wrap) begin
            clock_out_d = 1'b0;
        end else if (at_half) begin
            clock_out_d = 1'b1;
            tick_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            half_q      <= HalfRst;
            shadow_q    <= '0;
            busy_q      <= 1'b0;
            clock_out_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            shadow_q    <= shadow_d;
            busy_q      <= busy_d;
            clock_out_q <= clock_out_d;
            tick_q      <= tick_d;
        end
    end

    assign bus.clock_out = clock_out_q;
    assign bus.tick      = tick_q;
    assign bus.busy      = busy_q;

`ifdef CONTROL_DIVISOR_STATUS_EN
    logic [15:0] periodos_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            periodos_q <= '0;
        end else if (run && at_wrap) begin
            periodos_q <= periodos_q + 16'd1;
        end
    end

    assign bus.periodos = periodos_q;
`endif

endmodule

// File: tb/tb_control_divisor.sv
// Scoreboard bench for control_divisor with HALF_DEFAULT = 3.
module tb_control_divisor;
    import divisor_pkg::*;

    localparam int unsigned N = 32;

    typedef struct packed {
        logic clk_o;
        logic tick;
        logic busy;
        logic ready;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    control_divisor_if #(.N(N)) bus ();

    control_divisor #(
        .N           (N),
        .HALF_DEFAULT(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    exp_t        sb_q[$];
    int unsigned tests    = 0;
    int unsigned failures = 0;
    int unsigned obs      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One entry per observed cycle; patterns are strings of '0'/'1'.
    task automatic push_seq(input string clk_pat, input string tick_pat,
                            input logic busy, input logic ready);
        for (int i = 0; i < clk_pat.len(); i++) begin
            exp_t e;
            e.clk_o = (clk_pat[i] == "1");
            e.tick  = (tick_pat[i] == "1");
            e.busy  = busy;
            e.ready = ready;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain();
        while (sb_q.size() > 0) begin
            exp_t e;
            @(negedge clk);
            e = sb_q.pop_front();
            obs++;
            check_eq($sformatf("clock_out[%0d]", obs), 32'(bus.clock_out), 32'(e.clk_o));
            check_eq($sformatf("tick[%0d]", obs), 32'(bus.tick), 32'(e.tick));
            check_eq($sformatf("busy[%0d]", obs), 32'(bus.busy), 32'(e.busy));
            check_eq($sformatf("cfg_ready[%0d]", obs), 32'(bus.cfg_ready), 32'(e.ready));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_clock_out"}, 32'(bus.clock_out), 32'd0);
        check_eq({tag, "_tick"}, 32'(bus.tick), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_cfg_ready"}, 32'(bus.cfg_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_half  = '0;
        #2;
        check_reset_outputs("reset");

        @(negedge clk);
        rst_n  = 1'b1;
        bus.en = 1'b1;
        push_seq("000111000111", "000100000100", 1'b0, 1'b1);
        drain();

        // Stop requested in the high phase: period completes, then idle.
        push_seq("0001", "0001", 1'b0, 1'b1);
        drain();
        bus.en = 1'b0;
        push_seq("11000", "00000", 1'b0, 1'b1);
        drain();

        // Stop withdrawn before the wrap: no gap.
        bus.en = 1'b1;
        push_seq("0001", "0001", 1'b0, 1'b1);
        drain();
        bus.en = 1'b0;
        push_seq("1", "0", 1'b0, 1'b1);
        drain();
        bus.en = 1'b1;
        push_seq("100011100", "000010000", 1'b0, 1'b1);
        drain();

        // New half-period offered mid low phase while running.
        bus.cfg_valid = 1'b1;
        bus.cfg_half  = 5;
        push_seq("0", "0", 1'b1, 1'b0);
        drain();
        bus.cfg_valid = 1'b0;
        push_seq("111", "100", 1'b1, 1'b0);
        push_seq("0000011111", "0000010000", 1'b0, 1'b1);
        drain();

        // Idle, zero half-period clamps to 1.
        bus.en = 1'b0;
        push_seq("00", "00", 1'b0, 1'b1);
        drain();
        bus.cfg_valid = 1'b1;
        bus.cfg_half  = 0;
        push_seq("0", "0", 1'b0, 1'b1);
        drain();
        bus.cfg_valid = 1'b0;
        bus.en        = 1'b1;
        push_seq("01010101", "01010101", 1'b0, 1'b1);
        drain();

        // Asynchronous reset in the high phase, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");

        @(negedge clk);
        rst_n = 1'b1;
        push_seq("000111000111000111000111", "000100000100000100000100", 1'b0, 1'b1);
        push_seq("0", "0", 1'b0, 1'b1);
        drain();
`ifdef CONTROL_DIVISOR_STATUS_EN
        check_eq("periodos", 32'(bus.periodos), 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
